// File: rtl/warp_imem_responder_pkg.sv
// Shared widths, reset defaults and request-entry layout for the warp
// instruction-memory responder.
`timescale 1ns/1ps
package warp_imem_responder_pkg;

  localparam int ADDR_W    = 39;
  localparam int DATA_W    = 64;
  localparam int DW_ADDR_W = ADDR_W - 3;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEFAULT = 39'h40_0000_0000;

  typedef struct packed {
    logic                 in_range;
    logic [DW_ADDR_W-1:0] dw_addr;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

  // Unsigned offset test; an address below base wraps to a huge offset.
  function automatic logic addr_in_range(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input int                size_log2
  );
    logic [ADDR_W-1:0] off;
    off = {addr[ADDR_W-1:3], 3'b000} - base;
    if (size_log2 >= ADDR_W) return 1'b1;
    return (off >> size_log2) == '0;
  endfunction

endpackage

// File: rtl/warp_imem_responder_if.sv
// Fetch-side and backing-memory-side signal bundle of the instruction
// memory responder, with modports for the requester and the responder.
`timescale 1ns/1ps
interface warp_imem_responder_if;
  import warp_imem_responder_pkg::*;

  // Fetch side: a request is taken on a rising edge with imem_ren and
  // imem_ready both high; imem_valid is a one-cycle beat, imem_err
  // qualifies it. Memory side: a read is taken when mem_req and mem_gnt
  // are both high; mem_rvalid returns one in-order beat per granted read.
  logic                 imem_ren;
  logic [ADDR_W-1:0]    imem_raddr;
  logic                 imem_ready;
  logic                 imem_valid;
  logic [DATA_W-1:0]    imem_rdata;
  logic                 imem_err;
  logic                 flush;
  logic                 mem_req;
  logic [DW_ADDR_W-1:0] mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [DATA_W-1:0]    mem_rdata;

  modport master (
    output imem_ren, imem_raddr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  imem_ready, imem_valid, imem_rdata, imem_err, mem_req, mem_addr
  );

  modport slave (
    input  imem_ren, imem_raddr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output imem_ready, imem_valid, imem_rdata, imem_err, mem_req, mem_addr
  );

endinterface

// File: rtl/warp_req_fifo.sv
// Circular request queue with synchronous clear; a push coincident with
// clear lands in the freshly emptied queue.
`timescale 1ns/1ps
module warp_req_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // A full queue refuses a push even when it is popping in the same cycle.
  assign do_push = i_push & (count_q != CW'(DEPTH));
  assign do_pop  = i_pop & (count_q != '0) & ~i_clr;

  always_comb begin
    wr_idx   = i_clr ? '0 : wr_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_idx) : wr_idx;
    rd_ptr_d = i_clr ? '0 : (do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q);
    if (i_clr) count_d = CW'(do_push);
    else       count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_idx] <= i_push_data;
  end

  assign o_pop_data = mem_q[rd_ptr_q];
  assign o_count    = count_q;

endmodule

// File: rtl/warp_imem_responder.sv
// Instruction-fetch responder: queues fetch reads, forwards in-range ones to
// backing memory, answers out-of-range ones with an error beat, in order.
`timescale 1ns/1ps
module warp_imem_responder
  import warp_imem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int                SIZE_LOG2 = 16,
  parameter int                QDEPTH    = 2,
  parameter int                MAX_OUTST = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_imem_ren,
  input  logic [ADDR_W-1:0]    i_imem_raddr,
  output logic                 o_imem_ready,
  output logic                 o_imem_valid,
  output logic [DATA_W-1:0]    o_imem_rdata,
  output logic                 o_imem_err,
  input  logic                 i_flush,
  output logic                 o_mem_req,
  output logic [DW_ADDR_W-1:0] o_mem_addr,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [DATA_W-1:0]    i_mem_rdata
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  req_entry_t          push_entry, head;
  logic [ENTRY_W-1:0]  head_raw;
  logic [CW-1:0]       q_count;
  logic                q_empty, q_full;
  logic                push, pop;
  logic                mem_req, grant, err_pop;
  logic                rvalid_eff, drop_beat;
  logic [OW-1:0]       outst_q, outst_d;
  logic [OW-1:0]       drop_q, drop_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  assign q_empty      = (q_count == '0);
  assign q_full       = (q_count == CW'(QDEPTH));
  assign o_imem_ready = ~q_full;
  assign push         = i_imem_ren & ~q_full;

  always_comb begin
    push_entry          = '0;
    push_entry.in_range = addr_in_range(i_imem_raddr, BASE_ADDR, SIZE_LOG2);
    push_entry.dw_addr  = i_imem_raddr[ADDR_W-1:3];
  end

  warp_req_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_req_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (i_flush),
    .i_push      (push),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_pop_data  (head_raw),
    .o_count     (q_count)
  );

  assign head = req_entry_t'(head_raw);

  // Error entries wait for every in-flight read (dropped or not) so the
  // error beat cannot overtake older data.
  assign mem_req    = ~q_empty & head.in_range & (outst_q != OW'(MAX_OUTST));
  assign grant      = mem_req & i_mem_gnt;
  assign err_pop    = ~q_empty & ~head.in_range & (outst_q == '0);
  assign pop        = grant | err_pop;
  assign rvalid_eff = i_mem_rvalid & (outst_q != '0);
  assign drop_beat  = rvalid_eff & (drop_q != '0);

  assign o_mem_req  = mem_req;
  assign o_mem_addr = mem_req ? head.dw_addr : '0;

  always_comb begin
    outst_d = outst_q;
    unique case ({grant, rvalid_eff})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // After a flush every read still in flight belongs to the old stream.
  always_comb begin
    drop_d = drop_q;
    if (i_flush)        drop_d = outst_d;
    else if (drop_beat) drop_d = drop_q - OW'(1);
  end

  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    if (!i_flush) begin
      if (rvalid_eff && !drop_beat) begin
        valid_d = 1'b1;
        rdata_d = i_mem_rdata;
      end else if (err_pop) begin
        valid_d = 1'b1;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outst_q <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_imem_valid = valid_q;
  assign o_imem_err   = err_q;
  assign o_imem_rdata = rdata_q;

endmodule

// File: tb/tb_warp_imem_responder.sv
// Directed bench for warp_imem_responder: cycle-exact checks plus an
// in-order response scoreboard fed with hand-computed beats.
`timescale 1ns/1ps
module tb_warp_imem_responder;
  import warp_imem_responder_pkg::*;

  localparam int RW = DATA_W + 1;

  logic clk;
  logic rst_n;
  logic mon_en;
  int   n_vec;
  int   n_miss;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;

  warp_imem_responder_if bus();

  warp_imem_responder dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_imem_ren   (bus.imem_ren),
    .i_imem_raddr (bus.imem_raddr),
    .o_imem_ready (bus.imem_ready),
    .o_imem_valid (bus.imem_valid),
    .o_imem_rdata (bus.imem_rdata),
    .o_imem_err   (bus.imem_err),
    .i_flush      (bus.flush),
    .o_mem_req    (bus.mem_req),
    .o_mem_addr   (bus.mem_addr),
    .i_mem_gnt    (bus.mem_gnt),
    .i_mem_rvalid (bus.mem_rvalid),
    .i_mem_rdata  (bus.mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_ren(input logic en, input logic [ADDR_W-1:0] addr);
    bus.imem_ren   = en;
    bus.imem_raddr = addr;
  endtask

  task automatic drive_beat(input logic en, input logic [DATA_W-1:0] data);
    bus.mem_rvalid = en;
    bus.mem_rdata  = data;
  endtask

  // scoreboard: every response beat must match the head of exp_q
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.imem_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", RW'({bus.imem_err, bus.imem_rdata}), RW'(0));
        end else begin
          mon_exp = exp_q.pop_front();
          chk("resp", {bus.imem_err, bus.imem_rdata}, mon_exp);
        end
      end else begin
        chk("idle_rdata", RW'({bus.imem_err, bus.imem_rdata}), RW'(0));
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    drive_ren(1'b0, '0);
    drive_beat(1'b0, '0);
    bus.flush   = 1'b0;
    bus.mem_gnt = 1'b0;
    #1;
    chk("rst_valid", RW'(bus.imem_valid), RW'(0));
    chk("rst_err",   RW'(bus.imem_err),   RW'(0));
    chk("rst_rdata", RW'(bus.imem_rdata), RW'(0));
    chk("rst_req",   RW'(bus.mem_req),    RW'(0));
    chk("rst_ready", RW'(bus.imem_ready), RW'(1));
    cyc();
    cyc();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc();

    // minimum-latency in-range read
    bus.mem_gnt = 1'b1;
    drive_ren(1'b1, 39'h40_0000_0008);
    cyc();
    drive_ren(1'b0, '0);
    chk("lat_req",     RW'(bus.mem_req),  RW'(1));
    chk("lat_addr",    RW'(bus.mem_addr), RW'(36'h8_0000_0001));
    chk("lat_novalid", RW'(bus.imem_valid), RW'(0));
    cyc();
    chk("lat_req_off", RW'(bus.mem_req), RW'(0));
    drive_beat(1'b1, 64'h1122_3344_5566_7788);
    exp_q.push_back({1'b0, 64'h1122_3344_5566_7788});
    cyc();
    drive_beat(1'b0, '0);
    chk("lat_valid_c3", RW'(bus.imem_valid), RW'(1));
    cyc();
    chk("lat_valid_one", RW'(bus.imem_valid), RW'(0));

    // address just below the region
    drive_ren(1'b1, 39'h3F_FFFF_FFF8);
    exp_q.push_back({1'b1, 64'h0});
    cyc();
    drive_ren(1'b0, '0);
    chk("oor_req0",   RW'(bus.mem_req),    RW'(0));
    chk("oor_early",  RW'(bus.imem_valid), RW'(0));
    cyc();
    chk("oor_req1",   RW'(bus.mem_req),    RW'(0));
    chk("oor_valid",  RW'(bus.imem_valid), RW'(1));
    chk("oor_err",    RW'(bus.imem_err),   RW'(1));
    cyc();

    // last in-range doubleword (low bits ignored), then first byte past the end
    bus.mem_gnt = 1'b0;
    drive_ren(1'b1, 39'h40_0000_FFFF);
    cyc();
    chk("bnd_req",  RW'(bus.mem_req),  RW'(1));
    chk("bnd_addr", RW'(bus.mem_addr), RW'(36'h8_0000_1FFF));
    bus.mem_gnt = 1'b1;
    drive_ren(1'b1, 39'h40_0001_0000);
    cyc();
    drive_ren(1'b0, '0);
    bus.mem_gnt = 1'b0;
    chk("bnd_oor_hold", RW'(bus.mem_req), RW'(0));
    drive_beat(1'b1, 64'hA5A5_0000_FFFF_0001);
    exp_q.push_back({1'b0, 64'hA5A5_0000_FFFF_0001});
    exp_q.push_back({1'b1, 64'h0});
    cyc();
    drive_beat(1'b0, '0);
    chk("bnd_data_first", RW'(bus.imem_valid), RW'(1));
    cyc();
    chk("bnd_err_next", RW'(bus.imem_err), RW'(1));
    cyc();

    // backpressure: grant withheld, third request dropped
    bus.mem_gnt = 1'b0;
    drive_ren(1'b1, 39'h40_0000_0010);
    cyc();
    chk("bp_ready1", RW'(bus.imem_ready), RW'(1));
    drive_ren(1'b1, 39'h40_0000_0018);
    cyc();
    chk("bp_ready2", RW'(bus.imem_ready), RW'(0));
    drive_ren(1'b1, 39'h40_0000_0020);
    cyc();
    drive_ren(1'b0, '0);
    chk("bp_ready3",   RW'(bus.imem_ready), RW'(0));
    chk("bp_addr_hold", RW'(bus.mem_addr), RW'(36'h8_0000_0002));
    bus.mem_gnt = 1'b1;
    cyc();
    chk("bp_ready_back", RW'(bus.imem_ready), RW'(1));
    chk("bp_addr2",      RW'(bus.mem_addr),   RW'(36'h8_0000_0003));
    drive_beat(1'b1, 64'h0000_0000_D1D1_D1D1);
    exp_q.push_back({1'b0, 64'h0000_0000_D1D1_D1D1});
    cyc();
    chk("bp_empty", RW'(bus.mem_req), RW'(0));
    drive_beat(1'b1, 64'h0000_0000_D2D2_D2D2);
    exp_q.push_back({1'b0, 64'h0000_0000_D2D2_D2D2});
    cyc();
    drive_beat(1'b0, '0);
    bus.mem_gnt = 1'b0;
    cyc();
    cyc();
    chk("bp_two_only", RW'(exp_q.size()), RW'(0));
    chk("bp_no_third", RW'(bus.mem_req),  RW'(0));

    // flush with two reads in flight and a new fetch in the same cycle
    bus.mem_gnt = 1'b1;
    drive_ren(1'b1, 39'h40_0000_0200);
    cyc();
    drive_ren(1'b1, 39'h40_0000_0208);
    cyc();
    drive_ren(1'b0, '0);
    cyc();
    bus.flush = 1'b1;
    drive_ren(1'b1, 39'h40_0000_0100);
    cyc();
    bus.flush = 1'b0;
    drive_ren(1'b0, '0);
    chk("fl_max_outst", RW'(bus.mem_req),    RW'(0));
    chk("fl_novalid",   RW'(bus.imem_valid), RW'(0));
    drive_beat(1'b1, 64'hDEAD_0000_0000_0001);
    cyc();
    chk("fl_drop1",  RW'(bus.imem_valid), RW'(0));
    chk("fl_req_c",  RW'(bus.mem_req),    RW'(1));
    chk("fl_addr_c", RW'(bus.mem_addr),   RW'(36'h8_0000_0020));
    drive_beat(1'b1, 64'hDEAD_0000_0000_0002);
    cyc();
    chk("fl_drop2", RW'(bus.imem_valid), RW'(0));
    chk("fl_req_c_done", RW'(bus.mem_req), RW'(0));
    drive_beat(1'b1, 64'h0100_0100_0100_0100);
    exp_q.push_back({1'b0, 64'h0100_0100_0100_0100});
    cyc();
    drive_beat(1'b0, '0);
    chk("fl_new_data", RW'(bus.imem_valid), RW'(1));
    cyc();

    // flush suppresses an error beat due in the same cycle
    bus.mem_gnt = 1'b0;
    drive_ren(1'b1, 39'h3F_FFFF_FFF8);
    cyc();
    drive_ren(1'b0, '0);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("fl_err_supp", RW'(bus.imem_valid), RW'(0));
    cyc();
    chk("fl_err_gone", RW'(bus.imem_valid), RW'(0));

    // out-of-range entry waits behind a slow in-range read
    bus.mem_gnt = 1'b1;
    drive_ren(1'b1, 39'h40_0000_0300);
    cyc();
    drive_ren(1'b1, 39'h50_0000_0000);
    cyc();
    drive_ren(1'b0, '0);
    bus.mem_gnt = 1'b0;
    chk("ord_no_req", RW'(bus.mem_req), RW'(0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ord_wait", RW'(bus.imem_valid), RW'(0));
    end
    drive_beat(1'b1, 64'h3030_3030_3030_3030);
    exp_q.push_back({1'b0, 64'h3030_3030_3030_3030});
    exp_q.push_back({1'b1, 64'h0});
    cyc();
    drive_beat(1'b0, '0);
    chk("ord_data",     RW'({bus.imem_valid, bus.imem_err}), RW'(2'b10));
    cyc();
    chk("ord_err_next", RW'({bus.imem_valid, bus.imem_err}), RW'(2'b11));
    cyc();

    // reset with a read in flight; its late beat must be ignored
    bus.mem_gnt = 1'b1;
    drive_ren(1'b1, 39'h40_0000_0400);
    cyc();
    drive_ren(1'b0, '0);
    cyc();
    bus.mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   RW'(bus.mem_req),    RW'(0));
    chk("mid_rst_ready", RW'(bus.imem_ready), RW'(1));
    chk("mid_rst_valid", RW'(bus.imem_valid), RW'(0));
    cyc();
    rst_n = 1'b1;
    drive_beat(1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
    cyc();
    drive_beat(1'b0, '0);
    chk("late_beat_ignored", RW'(bus.imem_valid), RW'(0));
    cyc();
    chk("late_beat_rdata", RW'(bus.imem_rdata), RW'(0));

    chk("exp_q_drained", RW'(exp_q.size()), RW'(0));
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
